// File: rtl/decimal_entry_pkg.sv
// Shared constants, state encoding and the BCD accumulate step for the decimal entry block.
package decimal_entry_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int RADIX      = 10;
  localparam int MAX_DIGIT  = 9;
  localparam int BIN_WIDTH  = 32;
  localparam int ACC_WIDTH  = 14;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // acc*RADIX + d with the multiply as shift-and-add; 9999 fits in ACC_WIDTH bits
  function automatic logic [ACC_WIDTH-1:0] mul10_add(input logic [ACC_WIDTH-1:0] acc,
                                                     input logic [3:0]           d);
    logic [ACC_WIDTH-1:0] x8;
    logic [ACC_WIDTH-1:0] x2;
    x8 = acc << 3;
    x2 = acc << 1;
    return x8 + x2 + ACC_WIDTH'(d);
  endfunction

endpackage

// File: rtl/decimal_entry_button_sync.sv
// Two-flop synchronizer plus rising-edge detector for one raw button.
module button_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync_p0, sync_p1, sync_p2;
  logic vld_p0, vld_p1;
  logic armed;

  // vld_pN marks that sync_pN holds a real post-reset sample; armed requires
  // seeing the button low once, so a button held through reset cannot fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      if (vld_p1 && !sync_p1)
        armed <= 1'b1;
    end
  end

  assign pulse = armed & sync_p1 & ~sync_p2;

endmodule

// File: rtl/decimal_entry.sv
// Four-digit BCD keypad entry with a serial multiply-by-ten BCD-to-binary converter.
module decimal_entry
  import decimal_entry_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           digit,
  input  logic                 push,
  input  logic                 enter,
  input  logic                 clear,
  output logic [BIN_WIDTH-1:0] binary,
  output logic                 valid,
  output logic                 busy,
  output logic [3:0]           digOnes,
  output logic [3:0]           digTens,
  output logic [3:0]           digHundreds,
  output logic [3:0]           digThousands
);

  localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

  logic push_pulse, enter_pulse, clear_pulse;

  button_sync u_push_sync (
    .clock (clock),
    .reset (reset),
    .btn   (push),
    .pulse (push_pulse)
  );

  button_sync u_enter_sync (
    .clock (clock),
    .reset (reset),
    .btn   (enter),
    .pulse (enter_pulse)
  );

  button_sync u_clear_sync (
    .clock (clock),
    .reset (reset),
    .btn   (clear),
    .pulse (clear_pulse)
  );

  state_t               state, state_n;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_n;
  logic [1:0]           idx;
  logic [3:0]           dig [NUM_DIGITS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // clear outranks enter, so enter only starts a conversion when clear is quiet
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!clear_pulse && enter_pulse) state_n = CONVERT;
      CONVERT: if (idx == 2'd0)                 state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign acc_n = mul10_add(acc, dig[idx]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      idx    <= 2'd3;
      binary <= '0;
      valid  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= 4'd0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_pulse) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= 4'd0;
          end else if (enter_pulse) begin
            acc <= '0;
            idx <= 2'd3;
          end else if (push_pulse && digit <= MAX_D) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) dig[i] <= dig[i-1];
            dig[0] <= digit;
          end
        end
        CONVERT: begin
          // most significant digit first; digit registers stay frozen here
          acc <= acc_n;
          idx <= idx - 2'd1;
          if (idx == 2'd0) begin
            binary <= BIN_WIDTH'(acc_n);
            valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state == CONVERT);
  assign digOnes      = dig[0];
  assign digTens      = dig[1];
  assign digHundreds  = dig[2];
  assign digThousands = dig[3];

endmodule
